noc_flit_responder: RTL and testbench

Network-side endpoint that terminates the single-flit request/response link of a processing element. Pops request flits from a PE output port using the valid/deq handshake. Decodes a 3-bit opcode, waits a fixed service latency, then queues a response flit that the PE's input port pops with the same handshake. Used as the far end of PE links in single-PE benches and as a stub endpoint in small NoC builds.

---
 rtl/noc_flit_responder_if.sv | 33 +++
 rtl/noc_flit_responder.sv | 179 +++++++++++++++++
 tb/tb_noc_flit_responder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_flit_responder_if.sv
// Single-flit request/response link between a processing element and the
// network responder. The master modport is the PE side; the slave modport is the responder.
interface noc_flit_responder_if #(
  parameter int WIDTH = 32
);
  // Handshake: the producer holds *_dataValid with stable data until the
  // consumer raises *_dataDeq in the same cycle. The flit transfers on that
  // rising clock edge. Deq is never raised while valid is low.
  logic [WIDTH-1:0] req_dataIn;
  logic             req_dataValid;
  logic             req_dataDeq;
  logic [WIDTH-1:0] rsp_dataOut;
  logic             rsp_dataValid;
  logic             rsp_dataDeq;

  modport master (
    output req_dataIn,
    output req_dataValid,
    input  req_dataDeq,
    input  rsp_dataOut,
    input  rsp_dataValid,
    output rsp_dataDeq
  );

  modport slave (
    input  req_dataIn,
    input  req_dataValid,
    output req_dataDeq,
    output rsp_dataOut,
    output rsp_dataValid,
    input  rsp_dataDeq
  );
endinterface

// File: rtl/noc_flit_responder.sv
// Far-end responder for a PE link: decodes request opcodes, waits LATENCY cycles, queues responses.
// Optional accept/dequeue tracing is enabled by defining NOC_RESPONDER_TRACE_EN.
module noc_flit_responder #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                CLK,
  input  logic                RST,
  noc_flit_responder_if.slave link,
  output logic [15:0]         rx_count,
  output logic [15:0]         tx_count,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam int PW = WIDTH - 4;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0]    OP_INCR = 3'd1;
  localparam logic [2:0]    OP_DROP = 3'd2;
  localparam logic [2:0]    OP_ERR  = 3'd7;
  localparam logic [3:0]    LAT     = 4'(LATENCY);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [2:0]      op_q, op_d;
  logic [PW-1:0]   pay_q, pay_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     rx_q, rx_d;
  logic [15:0]     tx_q, tx_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             accept;
  logic             q_full;
  logic             q_empty;
  logic             enq;
  logic             deq;
  logic [2:0]       op_out;
  logic [PW-1:0]    pay_out;
  logic [WIDTH-1:0] rsp_flit;
  logic             unused_req_msb;

  assign unused_req_msb = link.req_dataIn[WIDTH-1];

  assign q_full  = (count_q == FULL);
  assign q_empty = (count_q == '0);

  // Request pop is combinational so the PE sees it in the same cycle; reset gates it off.
  assign accept           = RST && (state_q == S_IDLE) && link.req_dataValid;
  assign link.req_dataDeq = accept;

  // Fullness is judged on the count at cycle start, so a same-cycle pop never makes room.
  assign enq = (state_q == S_PUSH) && (op_q != OP_DROP) && !q_full;
  assign deq = link.rsp_dataDeq && !q_empty;

  always_comb begin
    op_out   = (op_q >= 3'd3) ? OP_ERR : op_q;
    pay_out  = (op_q == OP_INCR) ? (pay_q + PW'(1)) : pay_q;
    rsp_flit = {1'b0, op_out, pay_out};
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    op_d    = op_q;
    pay_d   = pay_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = link.req_dataIn[WIDTH-2:WIDTH-4];
          pay_d   = link.req_dataIn[PW-1:0];
          wcnt_d  = LAT;
          state_d = (LAT != 4'd0) ? S_WAIT : S_PUSH;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) begin
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if ((op_q == OP_DROP) || !q_full) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      tx_d     = tx_q + 16'd1;
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (accept) begin
      rx_d = rx_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      op_q     <= '0;
      pay_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      op_q     <= op_d;
      pay_q    <= pay_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
    end
  end

  // Storage needs no reset: the output is masked to zero whenever the queue is empty.
  always_ff @(posedge CLK) begin
    if (RST && enq) begin
      mem_q[wr_ptr_q] <= rsp_flit;
    end
  end

  assign link.rsp_dataOut   = q_empty ? '0 : mem_q[rd_ptr_q];
  assign link.rsp_dataValid = !q_empty;
  assign rx_count           = rx_q;
  assign tx_count           = tx_q;
  assign busy               = (state_q != S_IDLE) || !q_empty;
  assign dbg_state          = state_q;

`ifdef NOC_RESPONDER_TRACE_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      if (accept) begin
        $display("RSP: req op=%0d payload=0x%07x",
                 link.req_dataIn[WIDTH-2:WIDTH-4], link.req_dataIn[PW-1:0]);
      end
      if (deq) begin
        $display("RSP: sent flit [0x%08x]", link.rsp_dataOut);
      end
    end
  end
`else
  // Tracing disabled: no display logic is built.
`endif

endmodule

// File: tb/tb_noc_flit_responder.sv
// Directed bench for noc_flit_responder (WIDTH=32, DEPTH=4, LATENCY=2).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled in the same window.
module tb_noc_flit_responder;
  localparam int W = 32;
  localparam int D = 4;
  localparam int L = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_PUSH = 2'd2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rx_count;
  logic [15:0] tx_count;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  noc_flit_responder_if #(.WIDTH(W)) link ();

  noc_flit_responder #(.WIDTH(W), .DEPTH(D), .LATENCY(L)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .link      (link),
    .rx_count  (rx_count),
    .tx_count  (tx_count),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle_start();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Holds a request until popped; returns in the drive window of the cycle after the accept.
  task automatic send(input string tag, input logic [W-1:0] f, input int bound);
    bit acc;
    acc = 1'b0;
    link.req_dataIn    = f;
    link.req_dataValid = 1'b1;
    for (int i = 0; i < bound && !acc; i++) begin
      #1;
      if (link.req_dataDeq) acc = 1'b1;
      cycle_start();
    end
    link.req_dataValid = 1'b0;
    link.req_dataIn    = '0;
    check({tag, "_accepted"}, W'(acc), 1);
  endtask

  task automatic wait_valid(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (link.rsp_dataValid) begin
        seen = 1'b1;
        break;
      end
      cycle_start();
    end
    check({tag, "_valid_seen"}, W'(seen), 1);
  endtask

  task automatic pop_expect(input string tag);
    logic [W-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check({tag, "_valid"}, W'(link.rsp_dataValid), 1);
    check({tag, "_data"}, link.rsp_dataOut, e);
    link.rsp_dataDeq = 1'b1;
    cycle_start();
    link.rsp_dataDeq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc6;
    link.req_dataIn    = '0;
    link.req_dataValid = 1'b0;
    link.rsp_dataDeq   = 1'b0;

    // Reset state, with a request offered while reset is held.
    cycle_start();
    cycle_start();
    link.req_dataValid = 1'b1;
    #1;
    check("rst_req_deq", W'(link.req_dataDeq), 0);
    check("rst_rsp_valid", W'(link.rsp_dataValid), 0);
    check("rst_rsp_data", link.rsp_dataOut, 0);
    check("rst_rx", W'(rx_count), 0);
    check("rst_tx", W'(tx_count), 0);
    check("rst_busy", W'(busy), 0);
    check("rst_state", W'(dbg_state), W'(ST_IDLE));
    link.req_dataValid = 1'b0;
    rst_n = 1'b1;

    // Pop while empty must be ignored.
    link.rsp_dataDeq = 1'b1;
    cycle_start();
    link.rsp_dataDeq = 1'b0;
    check("empty_pop_tx", W'(tx_count), 0);
    check("empty_pop_valid", W'(link.rsp_dataValid), 0);

    // ECHO accepted in cycle 10: WAIT 11-12, PUSH 13, valid 14.
    while (cyc < 10) cycle_start();
    exp_q.push_back(32'h0000_0005);
    send("echo", 32'h0000_0005, 4);
    check("echo_c11_state", W'(dbg_state), W'(ST_WAIT));
    check("echo_c11_rx", W'(rx_count), 1);
    check("echo_c11_valid", W'(link.rsp_dataValid), 0);
    cycle_start();
    check("echo_c12_state", W'(dbg_state), W'(ST_WAIT));
    check("echo_c12_valid", W'(link.rsp_dataValid), 0);
    cycle_start();
    check("echo_c13_state", W'(dbg_state), W'(ST_PUSH));
    check("echo_c13_valid", W'(link.rsp_dataValid), 0);
    check("echo_c13_busy", W'(busy), 1);
    cycle_start();
    check("echo_c14_valid", W'(link.rsp_dataValid), 1);
    pop_expect("echo");
    check("echo_rx", W'(rx_count), 1);
    check("echo_tx", W'(tx_count), 1);
    check("echo_after_valid", W'(link.rsp_dataValid), 0);
    check("echo_after_busy", W'(busy), 0);

    // INCR payload wraps to zero.
    exp_q.push_back(32'h1000_0000);
    send("incr", 32'h1FFF_FFFF, 4);
    wait_valid("incr", 8);
    pop_expect("incr");

    // DROP: never valid, busy clears at N+L+2.
    send("drop", 32'h2000_0001, 4);
    check("drop_n1_valid", W'(link.rsp_dataValid), 0);
    check("drop_n1_busy", W'(busy), 1);
    cycle_start();
    check("drop_n2_valid", W'(link.rsp_dataValid), 0);
    cycle_start();
    check("drop_n3_state", W'(dbg_state), W'(ST_PUSH));
    check("drop_n3_valid", W'(link.rsp_dataValid), 0);
    cycle_start();
    check("drop_n4_busy", W'(busy), 0);
    check("drop_n4_valid", W'(link.rsp_dataValid), 0);
    check("drop_n4_state", W'(dbg_state), W'(ST_IDLE));
    check("drop_rx", W'(rx_count), 3);
    check("drop_tx", W'(tx_count), 2);

    // ERROR opcodes (5 with bit 31 set, and 3) report opcode 7.
    exp_q.push_back(32'h7000_0ABC);
    send("err5", 32'hD000_0ABC, 4);
    wait_valid("err5", 8);
    pop_expect("err5");
    exp_q.push_back(32'h7000_0001);
    send("err3", 32'h3000_0001, 4);
    wait_valid("err3", 8);
    pop_expect("err3");
    check("err_rx", W'(rx_count), 5);
    check("err_tx", W'(tx_count), 4);

    // Fill the queue with no pops: 4 queued, 5th stalls in PUSH, 6th is held off.
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(32'h0000_0010 + W'(k));
      send("fill", 32'h0000_0010 + W'(k), 12);
    end
    cycle_start();
    cycle_start();
    link.req_dataIn    = 32'h0000_0015;
    link.req_dataValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("stall_req_deq", W'(link.req_dataDeq), 0);
      check("stall_state", W'(dbg_state), W'(ST_PUSH));
      check("stall_head", link.rsp_dataOut, 32'h0000_0010);
      check("stall_busy", W'(busy), 1);
      cycle_start();
    end
    check("stall_rx", W'(rx_count), 10);
    exp_q.push_back(32'h0000_0015);
    acc6 = 1'b0;
    link.rsp_dataDeq = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
      #1;
      if (link.rsp_dataValid) check("drain_data", link.rsp_dataOut, exp_q.pop_front());
      if (link.req_dataValid && link.req_dataDeq) acc6 = 1'b1;
      cycle_start();
      if (acc6) link.req_dataValid = 1'b0;
    end
    link.rsp_dataDeq   = 1'b0;
    link.req_dataValid = 1'b0;
    check("drain_left", W'(exp_q.size()), 0);
    check("drain_acc6", W'(acc6), 1);
    check("drain_rx", W'(rx_count), 11);
    check("drain_tx", W'(tx_count), 10);
    check("drain_valid", W'(link.rsp_dataValid), 0);
    check("drain_busy", W'(busy), 0);

    // Reset during WAIT with two responses queued.
    send("pre_a", 32'h0000_0021, 8);
    send("pre_b", 32'h0000_0022, 8);
    send("pre_c", 32'h0000_0023, 8);
    check("pre_state", W'(dbg_state), W'(ST_WAIT));
    check("pre_valid", W'(link.rsp_dataValid), 1);
    rst_n              = 1'b0;
    link.req_dataIn    = 32'h0000_0024;
    link.req_dataValid = 1'b1;
    #1;
    check("mid_rst_req_deq", W'(link.req_dataDeq), 0);
    cycle_start();
    rst_n              = 1'b1;
    link.req_dataValid = 1'b0;
    check("post_rst_valid", W'(link.rsp_dataValid), 0);
    check("post_rst_data", link.rsp_dataOut, 0);
    check("post_rst_rx", W'(rx_count), 0);
    check("post_rst_tx", W'(tx_count), 0);
    check("post_rst_busy", W'(busy), 0);
    check("post_rst_state", W'(dbg_state), W'(ST_IDLE));
    for (int k = 0; k < 3; k++) cycle_start();
    check("post_rst_no_push", W'(link.rsp_dataValid), 0);
    exp_q.delete();
    exp_q.push_back(32'h0000_0033);
    send("post", 32'h0000_0033, 4);
    wait_valid("post", 8);
    pop_expect("post");
    check("post_rx", W'(rx_count), 1);
    check("post_tx", W'(tx_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
